// File: rtl/fir_pkg.sv
// ---------------------------------------------------------------------------
// fir_pkg : shared FSM state type and arithmetic helpers for fir_tdm_mac
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int RS_W = 64;

  function automatic int acc_width(input int data_w, input int coef_w, input int ntaps);
    return data_w + coef_w + $clog2(ntaps);
  endfunction

  // Round half up at the coefficient binary point, then clamp to the data range.
  function automatic logic signed [RS_W-1:0] round_sat(input logic signed [RS_W-1:0] acc,
                                                       input int coef_frac,
                                                       input int data_w);
    logic signed [RS_W-1:0] half;
    logic signed [RS_W-1:0] r;
    logic signed [RS_W-1:0] hi;
    logic signed [RS_W-1:0] lo;
    r = acc;
    if (coef_frac > 0) begin
      half = 64'sd1 <<< (coef_frac - 1);
      r    = (acc + half) >>> coef_frac;
    end
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (data_w - 1));
    if (r > hi) begin
      r = hi;
    end else if (r < lo) begin
      r = lo;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_mac_unit.sv
// ---------------------------------------------------------------------------
// fir_mac_unit : signed multiplier feeding a clearable full-precision accumulator
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_mac_unit #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = 19
) (
  input  logic                     clock,
  input  logic                     nreset,
  input  logic                     clr_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [COEF_W-1:0] b_i,
  output logic signed [ACC_W-1:0]  acc_o
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_d;

  assign prod = a_i * b_i;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

`default_nettype wire

// File: rtl/fir_tdm_mac.sv
// ---------------------------------------------------------------------------
// fir_tdm_mac : programmable FIR sharing one MAC across NTAPS cycles per output
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fir_tdm_mac
  import fir_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int COEF_W    = 8,
  parameter int COEF_FRAC = 7,
  parameter int NTAPS     = 10
) (
  input  logic                       clock,
  input  logic                       nreset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic signed [DATA_W-1:0]   in_data,
  output logic                       out_valid,
  output logic signed [DATA_W-1:0]   out_data,
  input  logic                       coef_we,
  input  logic [$clog2(NTAPS)-1:0]   coef_addr,
  input  logic signed [COEF_W-1:0]   coef_wdata,
  output logic                       busy
);

  localparam int ADDR_W = $clog2(NTAPS);
  localparam int ACC_W  = acc_width(DATA_W, COEF_W, NTAPS);

  state_t                    state_q;
  state_t                    state_d;
  logic [ADDR_W-1:0]         k_q;
  logic [ADDR_W-1:0]         k_d;
  logic signed [DATA_W-1:0]  x_q [NTAPS];
  logic signed [COEF_W-1:0]  c_q [NTAPS];
  logic signed [ACC_W-1:0]   acc;
  logic signed [DATA_W-1:0]  sat_val;
  logic signed [DATA_W-1:0]  out_data_q;
  logic                      out_valid_q;
  logic                      accept;
  logic                      last_tap;
  logic                      coef_wr;

  assign accept   = in_valid && (state_q == IDLE);
  assign last_tap = (k_q == ADDR_W'(NTAPS - 1));
  assign coef_wr  = coef_we && (state_q == IDLE) && (int'(coef_addr) < NTAPS);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = MAC;
          k_d     = '0;
        end
      end
      MAC: begin
        if (last_tap) begin
          state_d = OUT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  // A write landing on the accept edge is already visible when MAC starts.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else begin
      if (coef_wr) begin
        c_q[coef_addr] <= coef_wdata;
      end
      if (accept) begin
        x_q[0] <= in_data;
        for (int i = 1; i < NTAPS; i++) begin
          x_q[i] <= x_q[i-1];
        end
      end
    end
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clock  (clock),
    .nreset (nreset),
    .clr_i  (accept),
    .en_i   (state_q == MAC),
    .a_i    (x_q[k_q]),
    .b_i    (c_q[k_q]),
    .acc_o  (acc)
  );

  assign sat_val = DATA_W'(round_sat({{(RS_W-ACC_W){acc[ACC_W-1]}}, acc}, COEF_FRAC, DATA_W));

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= (state_q == OUT);
      if (state_q == OUT) begin
        out_data_q <= sat_val;
      end
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

`default_nettype wire

// File: tb/tb_fir_tdm_mac.sv
// ---------------------------------------------------------------------------
// tb_fir_tdm_mac : randomized self-checking bench against a plain-arithmetic FIR model
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fir_tdm_mac;

  localparam int DATA_W    = 8;
  localparam int COEF_W    = 8;
  localparam int COEF_FRAC = 7;
  localparam int NTAPS     = 4;

  logic                     clock = 1'b0;
  logic                     nreset = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_data = '0;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  logic                     coef_we = 1'b0;
  logic [1:0]               coef_addr = '0;
  logic signed [COEF_W-1:0] coef_wdata = '0;
  logic                     busy;

  int checks = 0;
  int errors = 0;
  int m_hist [NTAPS];
  int m_coef [NTAPS];

  fir_tdm_mac #(
    .DATA_W    (DATA_W),
    .COEF_W    (COEF_W),
    .COEF_FRAC (COEF_FRAC),
    .NTAPS     (NTAPS)
  ) dut (
    .clock      (clock),
    .nreset     (nreset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: y = clamp(floor((sum x[k]*c[k] + 2^(F-1)) / 2^F))
  function automatic int model_out();
    longint s;
    longint v;
    longint q;
    longint den;
    s = 0;
    for (int i = 0; i < NTAPS; i++) s += longint'(m_hist[i]) * longint'(m_coef[i]);
    den = longint'(2 ** COEF_FRAC);
    v = s + den / 2;
    q = v / den;
    if ((v % den != 0) && (v < 0)) q = q - 1;
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return int'(q);
  endfunction

  task automatic model_push(input int x);
    for (int i = NTAPS - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
    m_hist[0] = x;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NTAPS; i++) begin
      m_hist[i] = 0;
      m_coef[i] = 0;
    end
  endtask

  task automatic write_coef(input int addr, input int val);
    @(negedge clock);
    coef_we    = 1'b1;
    coef_addr  = addr[1:0];
    coef_wdata = val[7:0];
    @(posedge clock);
    #1 coef_we = 1'b0;
    m_coef[addr] = val;
  endtask

  task automatic wait_out(output int got, output bit seen);
    seen = 1'b0;
    got  = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clock);
      if (out_valid) begin
        seen = 1'b1;
        got  = int'(out_data);
      end
    end
  endtask

  task automatic run_sample(input int x, output int got, output bit seen);
    int t;
    @(negedge clock);
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      t++;
    end
    in_valid = 1'b1;
    in_data  = x[7:0];
    @(posedge clock);
    model_push(x);
    #1 in_valid = 1'b0;
    wait_out(got, seen);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (out_data !== 8'sd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    @(negedge clock);
    nreset = 1'b1;
    @(posedge clock);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    model_clear();
  endtask

  task automatic test_impulse();
    int exp_tbl [5] = '{50, 25, 13, 6, 0};
    int in_tbl [5]  = '{100, 0, 0, 0, 0};
    int got;
    bit seen;
    write_coef(0, 64); write_coef(1, 32); write_coef(2, 16); write_coef(3, 8);
    for (int i = 0; i < 5; i++) begin
      run_sample(in_tbl[i], got, seen);
      checks++;
      if (!seen || got !== exp_tbl[i]) begin
        errors++;
        $display("FAIL impulse[%0d]: got %0d (seen %0b) expected %0d", i, got, seen, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int got;
    bit seen;
    for (int i = 0; i < NTAPS; i++) write_coef(i, 127);
    for (int i = 0; i < 8; i++) begin
      run_sample((i < 4) ? 127 : -128, got, seen);
      checks++;
      if (!seen || got !== model_out()) begin
        errors++;
        $display("FAIL saturation[%0d]: got %0d (seen %0b) expected %0d", i, got, seen, model_out());
      end
    end
    checks++; if (got !== -128) begin errors++; $display("FAIL saturation_neg_final: got %0d expected -128", got); end
  endtask

  task automatic test_handshake();
    int cur;
    bit exp_pulse;
    for (int i = 0; i < NTAPS; i++) write_coef(i, int'($urandom_range(0, 255)) - 128);
    @(negedge clock);
    cur      = int'($urandom_range(0, 255)) - 128;
    in_valid = 1'b1;
    in_data  = cur[7:0];
    for (int n = 0; n < 18; n++) begin
      @(posedge clock);
      if (n % 6 == 0) model_push(cur);
      #1;
      exp_pulse = (n % 6 == 5);
      checks++; if (out_valid !== exp_pulse) begin errors++; $display("FAIL hs_out_valid edge %0d: got %b expected %b", n, out_valid, exp_pulse); end
      checks++; if (busy !== !exp_pulse) begin errors++; $display("FAIL hs_busy edge %0d: got %b expected %b", n, busy, !exp_pulse); end
      checks++; if (in_ready !== exp_pulse) begin errors++; $display("FAIL hs_in_ready edge %0d: got %b expected %b", n, in_ready, exp_pulse); end
      if (exp_pulse) begin
        checks++;
        if (int'(out_data) !== model_out()) begin
          errors++;
          $display("FAIL hs_data edge %0d: got %0d expected %0d", n, out_data, model_out());
        end
      end
      @(negedge clock);
      if (n == 17) begin
        in_valid = 1'b0;
      end else begin
        cur     = int'($urandom_range(0, 255)) - 128;
        in_data = cur[7:0];
      end
    end
  endtask

  task automatic test_busy_write();
    int got;
    bit seen;
    write_coef(0, 64); write_coef(1, 32); write_coef(2, 16); write_coef(3, 8);
    for (int i = 0; i < NTAPS; i++) begin
      run_sample(0, got, seen);
      checks++; if (!seen || got !== model_out()) begin errors++; $display("FAIL busy_flush[%0d]: got %0d (seen %0b) expected %0d", i, got, seen, model_out()); end
    end
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'sd100;
    @(posedge clock);
    model_push(100);
    #1 in_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clock);
      coef_we    = 1'b1;
      coef_addr  = 2'(j);
      coef_wdata = 8'sd127;
      @(posedge clock);
      #1 coef_we = 1'b0;
    end
    wait_out(got, seen);
    checks++; if (!seen || got !== 50) begin errors++; $display("FAIL busy_write_impulse: got %0d (seen %0b) expected 50", got, seen); end
    run_sample(0, got, seen);
    checks++; if (!seen || got !== 25) begin errors++; $display("FAIL busy_write_tap1: got %0d (seen %0b) expected 25", got, seen); end
  endtask

  task automatic test_same_edge();
    int got;
    bit seen;
    for (int i = 0; i < NTAPS; i++) begin
      run_sample(0, got, seen);
      checks++; if (!seen || got !== model_out()) begin errors++; $display("FAIL same_flush[%0d]: got %0d (seen %0b) expected %0d", i, got, seen, model_out()); end
    end
    @(negedge clock);
    in_valid   = 1'b1;
    in_data    = 8'sd100;
    coef_we    = 1'b1;
    coef_addr  = 2'd0;
    coef_wdata = 8'sd32;
    @(posedge clock);
    model_push(100);
    m_coef[0] = 32;
    #1;
    in_valid = 1'b0;
    coef_we  = 1'b0;
    wait_out(got, seen);
    checks++; if (!seen || got !== 25) begin errors++; $display("FAIL same_edge: got %0d (seen %0b) expected 25", got, seen); end
  endtask

  task automatic test_reset_mid();
    int exp_tbl [4] = '{50, 25, 13, 6};
    int in_tbl [4]  = '{100, 0, 0, 0};
    int got;
    bit seen;
    bit pulse = 1'b0;
    @(negedge clock);
    in_valid = 1'b1;
    in_data  = 8'sd77;
    @(posedge clock);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 nreset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
    checks++; if (out_data !== 8'sd0) begin errors++; $display("FAIL midreset_out_data: got %0d expected 0", out_data); end
    for (int n = 0; n < 12; n++) begin
      @(negedge clock);
      if (out_valid) pulse = 1'b1;
      if (n == 2) nreset = 1'b1;
    end
    checks++; if (pulse !== 1'b0) begin errors++; $display("FAIL midreset_no_pulse: got %b expected 0", pulse); end
    model_clear();
    write_coef(0, 64); write_coef(1, 32); write_coef(2, 16); write_coef(3, 8);
    for (int i = 0; i < 4; i++) begin
      run_sample(in_tbl[i], got, seen);
      checks++;
      if (!seen || got !== exp_tbl[i]) begin
        errors++;
        $display("FAIL midreset_impulse[%0d]: got %0d (seen %0b) expected %0d", i, got, seen, exp_tbl[i]);
      end
    end
  endtask

  task automatic test_random();
    int got;
    bit seen;
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0) begin
        for (int k = 0; k < NTAPS; k++) write_coef(k, int'($urandom_range(0, 255)) - 128);
      end
      run_sample(int'($urandom_range(0, 255)) - 128, got, seen);
      checks++;
      if (!seen || got !== model_out()) begin
        errors++;
        $display("FAIL random[%0d]: got %0d (seen %0b) expected %0d", i, got, seen, model_out());
      end
    end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_saturation();
    test_handshake();
    test_busy_write();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fir_tdm_mac.md
Name: fir_tdm_mac

Overview:
Parametrised signed FIR filter with runtime-programmable coefficients. A single time-multiplexed multiply-accumulate datapath computes each output over NTAPS cycles, replacing one multiplier per tap. It uses a valid/ready sample input, a valid-pulse output, full-precision accumulation, and round plus saturate back to the data width. It sits in the filter chain between a sample source and a downstream consumer that never applies backpressure.

Parameters:
DATA_W, 8, sample width, signed two's complement
COEF_W, 8, coefficient width, signed
COEF_FRAC, 7, fractional bits of coefficient (Q1.7 at default)
NTAPS, 10, number of taps, ≥2
(derived localparams: ADDR_W = $clog2(NTAPS); ACC_W = DATA_W+COEF_W+$clog2(NTAPS))

Ports:
clock  in  1  system clock, rising edge
nreset  in  1  asynchronous active-low reset
in_valid  in  1  in_data valid
in_ready  out  1  block can accept a sample
in_data  in  DATA_W  signed input sample
out_valid  out  1  one-cycle pulse, out_data valid
out_data  out  DATA_W  signed filtered output
coef_we  in  1  coefficient write strobe
coef_addr  in  ADDR_W  coefficient index (tap k)
coef_wdata  in  COEF_W  signed coefficient value
busy  out  1  high while state ≠ IDLE

Behaviour:
- Reset (async on nreset low): state=IDLE, delay line, coefficients, accumulator, tap counter, out_data all 0; out_valid=0; busy=0; in_ready=1 once nreset is released.
- Reset asserted mid-operation discards the computation in progress. No out_valid is produced for it.
- FSM IDLE→MAC→OUT→IDLE.
  - IDLE: in_ready=1. Accept occurs when in_valid&&in_ready at an edge (E0). On accept: shift the delay line (x[k]←x[k-1], x[0]←in_data), clear acc, k←0, go to MAC.
  - MAC: one accumulation per edge, acc += x[k]*c[k] at full precision (ACC_W, signed). The edge with k==NTAPS-1 goes to OUT. Edges E1..E_NTAPS.
  - OUT: at edge E_NTAPS+1, register out_data=sat(round(acc)), set out_valid=1 for exactly one cycle, and go to IDLE.
- Latency: accept edge to out_valid rising edge = NTAPS+1 edges. Throughput: one sample per NTAPS+2 cycles.
- in_valid outside IDLE is ignored, with no sample accepted. in_data is sampled only on accept.
- Rounding: acc + 2^(COEF_FRAC-1), then arithmetic shift right by COEF_FRAC (round half up).
- Saturation: clamp to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Coefficient writes are honoured only when busy=0. Writes while busy=1 are ignored. Writes with coef_addr≥NTAPS are ignored.
- A coefficient write and a sample accept on the same edge: the write lands, and the new value is used for that sample's computation.
- out_data holds its last value between pulses.

Decomposition:
- Package fir_pkg:
  - state typedef enum {IDLE, MAC, OUT}
  - function acc_width(DATA_W, COEF_W, NTAPS)
  - function round_sat(acc) parametrised by COEF_FRAC and DATA_W
- Sub-module fir_mac_unit: signed multiplier plus accumulator with clr/en inputs, ACC_W-wide.
- The FSM, delay line and coefficient register file stay in fir_tdm_mac.

Test Plan (DATA_W=8, COEF_W=8, COEF_FRAC=7, NTAPS=4):
1. Impulse: coefs {64,32,16,8}; inputs 100,0,0,0,0 → outputs 50,25,13,6,0.
2. Saturation:
   - coefs all 127, four inputs of 127 → last output 127 (raw 504).
   - Four inputs of -128 → last output -128 (raw -508).
3. Handshake: in_valid held high → accepts at edges 0,6,12; out_valid pulses after edges 5,11,17, each one cycle wide; busy low only in the accept cycles.
4. Busy write: write coef_addr=0 value 127 during MAC → ignored; next impulse of 100 with coefs {64,...} still yields 50. coef_addr=5 writes are also ignored.
5. Same-edge write and accept: write c[0]=32 on the accept edge of sample 100 → output 25.
6. Reset mid-MAC: pull nreset low at accept+2 → no out_valid. Delay line is cleared, so impulse 100 afterwards yields 50,25,13,6 with coefs reprogrammed after reset.
